// File: rtl/alu_pkg.sv
// Shared types and named commands for the 74181-style ALU core and its pipeline wrapper.
package alu_pkg;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } alu_flags_t;

  typedef struct packed {
    logic [3:0] s;
    logic       cin;
    logic       m;
  } alu_cmd_t;

  // Cin is active-low: a command with cin=0 adds one to the arithmetic result.
  localparam alu_cmd_t CMD_ADD  = 6'b100110;
  localparam alu_cmd_t CMD_ADDC = 6'b100100;
  localparam alu_cmd_t CMD_SUB  = 6'b011000;
  localparam alu_cmd_t CMD_XOR  = 6'b011011;
  localparam alu_cmd_t CMD_XNOR = 6'b100101;

  function automatic logic is_logic_mode(input alu_cmd_t cmd);
    return cmd.m;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit 74181-style function unit (active-high data) with C/V/N/Z flag generation.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_cmd_t         cmd,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] p_term;
  logic [WIDTH-1:0] g_term;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] logic_res;
  logic             logic_mode;

  // Every arithmetic function is P + G + carry, where S1/S0 pick the OR-like term and S3/S2 the AND-like term.
  always_comb begin
    p_term = a | (b & {WIDTH{cmd.s[0]}}) | (~b & {WIDTH{cmd.s[1]}});
    g_term = (a & b & {WIDTH{cmd.s[3]}}) | (a & ~b & {WIDTH{cmd.s[2]}});
    sum    = {1'b0, p_term} + {1'b0, g_term} + {{WIDTH{1'b0}}, ~cmd.cin};
  end

  always_comb begin
    logic_res = '0;
    case (cmd.s)
      4'b0000: logic_res = ~a;
      4'b0001: logic_res = ~(a | b);
      4'b0010: logic_res = ~a & b;
      4'b0011: logic_res = '0;
      4'b0100: logic_res = ~(a & b);
      4'b0101: logic_res = ~b;
      4'b0110: logic_res = a ^ b;
      4'b0111: logic_res = a & ~b;
      4'b1000: logic_res = ~a | b;
      4'b1001: logic_res = ~(a ^ b);
      4'b1010: logic_res = b;
      4'b1011: logic_res = a & b;
      4'b1100: logic_res = '1;
      4'b1101: logic_res = a | ~b;
      4'b1110: logic_res = a | b;
      4'b1111: logic_res = a;
      default: logic_res = '0;
    endcase
  end

  assign logic_mode = is_logic_mode(cmd);

  // Carry and overflow only exist in arithmetic mode.
  always_comb begin
    result  = logic_mode ? logic_res : sum[MSB:0];
    flags.c = ~logic_mode & sum[WIDTH];
    flags.v = ~logic_mode & (p_term[MSB] == g_term[MSB]) & (sum[MSB] != p_term[MSB]);
    flags.n = result[MSB];
    flags.z = ~|result;
  end

endmodule

// File: rtl/alu_pipe.sv
// STAGES-deep valid/ready pipeline around alu_core with tag sideband and flush.
// Optional ALU_STICKY_EN adds sticky_v/sticky_c accumulators of consumed results, cleared by sticky_clr or flush.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [3:0]       S,
  input  logic             M,
  input  logic             Cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DO,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z,
`ifdef ALU_STICKY_EN
  input  logic             sticky_clr,
  output logic             sticky_v,
  output logic             sticky_c,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int LAST = STAGES - 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    alu_flags_t       flags;
    logic [TAG_W-1:0] tag;
  } slot_t;

  alu_cmd_t         core_cmd;
  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;
  slot_t            core_slot;

  slot_t            slot_q [STAGES];
  logic [STAGES-1:0] slot_valid;
  logic [STAGES-1:0] slot_load;
  logic             accept;

  assign core_cmd = {S, Cin, M};

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (opA),
    .b      (opB),
    .cmd    (core_cmd),
    .result (core_result),
    .flags  (core_flags)
  );

  assign core_slot = {core_result, core_flags, in_tag};

  // A slot may load when it is empty or its content moves on this edge; walking from the output
  // back lets empty slots downstream pull data forward so bubbles collapse.
  always_comb begin : load_chain
    logic downstream;
    downstream = out_ready;
    slot_load  = '0;
    for (int i = LAST; i >= 0; i--) begin
      slot_load[i] = ~slot_valid[i] | downstream;
      downstream   = slot_load[i];
    end
  end

  assign in_ready = ~flush & slot_load[0];
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      if (flush) begin
        slot_valid <= '0;
      end else begin
        if (slot_load[0]) begin
          slot_valid[0] <= in_valid;
        end
        for (int i = 1; i < STAGES; i++) begin
          if (slot_load[i]) begin
            slot_valid[i] <= slot_valid[i-1];
          end
        end
      end
      if (accept) begin
        slot_q[0] <= core_slot;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (slot_load[i] && slot_valid[i-1]) begin
          slot_q[i] <= slot_q[i-1];
        end
      end
    end
  end

  assign out_valid = slot_valid[LAST];
  assign DO        = slot_q[LAST].data;
  assign C         = slot_q[LAST].flags.c;
  assign V         = slot_q[LAST].flags.v;
  assign N         = slot_q[LAST].flags.n;
  assign Z         = slot_q[LAST].flags.z;
  assign out_tag   = slot_q[LAST].tag;

`ifdef ALU_STICKY_EN
  // Clearing takes priority, so a flag arriving in the clearing cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_v <= 1'b0;
      sticky_c <= 1'b0;
    end else if (sticky_clr || flush) begin
      sticky_v <= 1'b0;
      sticky_c <= 1'b0;
    end else if (out_valid && out_ready) begin
      sticky_v <= sticky_v | V;
      sticky_c <= sticky_c | C;
    end
  end
`endif

endmodule
